// File: rtl/fmap_channel_packer_if.sv
// fmap_channel_packer_if
// Stream bundle for the conv2 output packer.
//   s_* : filter-serial int8 input stream (one element per cycle, tagged
//         with filter index and pixel row/column), valid/ready.
//   m_* : channel-parallel pixel output stream, valid/ready.
// Modports:
//   master : producer/consumer side (drives s_* and m_ready).
//   slave  : the packer itself (drives s_ready and m_*).
interface fmap_channel_packer_if #(
  parameter int OUT_CH = 32,
  parameter int IMG_H  = 14,
  parameter int IMG_W  = 14,
  parameter int DATA_W = 8
);
  localparam int FILT_W = $clog2(OUT_CH);
  localparam int Y_W    = $clog2(IMG_H);
  localparam int X_W    = $clog2(IMG_W);

  logic signed [DATA_W-1:0]      s_data;
  logic [FILT_W-1:0]             s_filter;
  logic [Y_W-1:0]                s_y;
  logic [X_W-1:0]                s_x;
  logic                          s_valid;
  logic                          s_ready;

  logic [0:OUT_CH-1][DATA_W-1:0] m_pixel;
  logic [Y_W-1:0]                m_y;
  logic [X_W-1:0]                m_x;
  logic                          m_last;
  logic                          m_valid;
  logic                          m_ready;

  modport master (
    output s_data, s_filter, s_y, s_x, s_valid, m_ready,
    input  s_ready, m_pixel, m_y, m_x, m_last, m_valid
  );

  modport slave (
    input  s_data, s_filter, s_y, s_x, s_valid, m_ready,
    output s_ready, m_pixel, m_y, m_x, m_last, m_valid
  );
endinterface

// File: rtl/fmap_channel_packer.sv
// fmap_channel_packer
// Collects filter-serial int8 results from the conv2 requantizer and packs
// each pixel's OUT_CH values into one channel-parallel vector, presented on
// a valid/ready stream. Two banks are used ping-pong so one pixel can fill
// while the previous one drains.
// Ports:
//   clk           clock
//   rst           asynchronous active-high reset
//   i_flush       synchronous clear of the partial fill and both banks
//   bus           fmap_channel_packer_if.slave (s_* input, m_* output)
//   o_frame_done  one-cycle pulse after the last pixel of a frame leaves
//   o_err_seq     sticky flag: an element arrived out of filter/tag order
module fmap_channel_packer #(
  parameter int OUT_CH = 32,
  parameter int IMG_H  = 14,
  parameter int IMG_W  = 14,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  fmap_channel_packer_if.slave bus,
  output logic                 o_frame_done,
  output logic                 o_err_seq
);

  localparam int FILT_W = $clog2(OUT_CH);
  localparam int Y_W    = $clog2(IMG_H);
  localparam int X_W    = $clog2(IMG_W);

  localparam logic [FILT_W-1:0] LAST_FILT = FILT_W'(OUT_CH - 1);
  localparam logic [Y_W-1:0]    LAST_Y    = Y_W'(IMG_H - 1);
  localparam logic [X_W-1:0]    LAST_X    = X_W'(IMG_W - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL
  } bank_state_t;

  bank_state_t                   r_bankState [2];
  logic [0:OUT_CH-1][DATA_W-1:0] r_bankData  [2];
  logic [Y_W-1:0]                r_bankY     [2];
  logic [X_W-1:0]                r_bankX     [2];
  logic                          r_wrBank;
  logic                          r_rdBank;
  logic [FILT_W-1:0]             r_fillCnt;
  logic                          r_frameDone;
  logic                          r_errSeq;

  logic w_sReady;
  logic w_accept;
  logic w_mValid;
  logic w_mLast;
  logic w_drain;
  logic w_tagOk;
  logic w_inOrder;
  logic w_restart;
  logic w_write;
  logic w_complete;
  logic w_seqErr;

  // Input is blocked only while the write bank still holds an undrained
  // pixel; out-of-order elements are still taken (and dropped) so the
  // producer is never stalled by a sequence error.
  assign w_sReady = ~rst & (r_bankState[r_wrBank] != BANK_FULL) & ~i_flush;
  assign w_accept = bus.s_valid & w_sReady;

  // The tag is only meaningful once the first element of a fill has
  // captured it.
  assign w_tagOk   = (r_fillCnt == '0) |
                     ((bus.s_y == r_bankY[r_wrBank]) & (bus.s_x == r_bankX[r_wrBank]));
  assign w_inOrder = (bus.s_filter == r_fillCnt) & w_tagOk;

  // A filter-0 element that breaks the sequence starts a fresh pixel.
  assign w_restart  = ~w_inOrder & (bus.s_filter == '0);
  assign w_write    = w_accept & (w_inOrder | w_restart);
  assign w_complete = w_accept & w_inOrder & (r_fillCnt == LAST_FILT);
  assign w_seqErr   = w_accept & ~w_inOrder;

  assign w_mValid = (r_bankState[r_rdBank] == BANK_FULL);
  assign w_mLast  = (r_bankY[r_rdBank] == LAST_Y) & (r_bankX[r_rdBank] == LAST_X);
  assign w_drain  = w_mValid & bus.m_ready;

  // Output is a straight mux of the read bank, so it holds steady for as
  // long as the consumer stalls.
  assign bus.s_ready = w_sReady;
  assign bus.m_valid = w_mValid;
  assign bus.m_pixel = r_bankData[r_rdBank];
  assign bus.m_y     = r_bankY[r_rdBank];
  assign bus.m_x     = r_bankX[r_rdBank];
  assign bus.m_last  = w_mLast;

  assign o_frame_done = r_frameDone;
  assign o_err_seq    = r_errSeq;

  // Bank bookkeeping. In-order and restart writes both land in slot
  // s_filter, so one write path covers both. Completion and drain always
  // address different banks (the write bank is never FULL while being
  // written, the read bank must be FULL to drain), so both can update in
  // the same edge. Flush empties the banks but keeps the pointers and the
  // sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        r_bankState[b] <= BANK_EMPTY;
        r_bankData[b]  <= '0;
        r_bankY[b]     <= '0;
        r_bankX[b]     <= '0;
      end
      r_wrBank    <= 1'b0;
      r_rdBank    <= 1'b0;
      r_fillCnt   <= '0;
      r_frameDone <= 1'b0;
      r_errSeq    <= 1'b0;
    end else if (i_flush) begin
      r_bankState[0] <= BANK_EMPTY;
      r_bankState[1] <= BANK_EMPTY;
      r_fillCnt      <= '0;
      r_frameDone    <= 1'b0;
    end else begin
      r_frameDone <= w_drain & w_mLast;

      if (w_seqErr) begin
        r_errSeq <= 1'b1;
      end

      if (w_write) begin
        r_bankData[r_wrBank][bus.s_filter] <= bus.s_data;
        if (bus.s_filter == '0) begin
          r_bankY[r_wrBank] <= bus.s_y;
          r_bankX[r_wrBank] <= bus.s_x;
        end
      end

      if (w_complete) begin
        r_bankState[r_wrBank] <= BANK_FULL;
        r_wrBank              <= ~r_wrBank;
        r_fillCnt             <= '0;
      end else if (w_write) begin
        r_bankState[r_wrBank] <= BANK_FILLING;
        r_fillCnt             <= bus.s_filter + FILT_W'(1);
      end

      if (w_drain) begin
        r_bankState[r_rdBank] <= BANK_EMPTY;
        r_rdBank              <= ~r_rdBank;
      end
    end
  end

endmodule

// File: tb/tb_fmap_channel_packer.sv
// tb_fmap_channel_packer
// Self-checking bench for fmap_channel_packer. Expected pixels are pushed to
// a scoreboard queue as stimulus is driven and popped when the packer hands
// a vector over. Each scenario task also checks handshake timing inline.
module tb_fmap_channel_packer;

  localparam int OUT_CH = 32;
  localparam int IMG_H  = 14;
  localparam int IMG_W  = 14;
  localparam int DATA_W = 8;

  typedef logic [0:OUT_CH-1][DATA_W-1:0] pix_t;
  typedef struct {
    pix_t       pix;
    logic [3:0] y;
    logic [3:0] x;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic frameDone;
  logic errSeq;

  int          compared   = 0;
  int          mismatched = 0;
  int unsigned cyc        = 0;
  int unsigned lastHsCyc  = 0;
  exp_t        sbQueue[$];

  fmap_channel_packer_if #(
    .OUT_CH(OUT_CH), .IMG_H(IMG_H), .IMG_W(IMG_W), .DATA_W(DATA_W)
  ) bus ();

  fmap_channel_packer #(
    .OUT_CH(OUT_CH), .IMG_H(IMG_H), .IMG_W(IMG_W), .DATA_W(DATA_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (flush),
    .bus          (bus),
    .o_frame_done (frameDone),
    .o_err_seq    (errSeq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: a handshake at the coming edge pops one entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !flush && bus.m_valid && bus.m_ready) begin
      compared++;
      if (sbQueue.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_output: got pixel y=%0d x=%0d, expected no output",
                 bus.m_y, bus.m_x);
      end else begin
        e = sbQueue.pop_front();
        if (bus.m_pixel !== e.pix) begin
          mismatched++;
          $display("[TB] FAIL sb_pixel: got %h, expected %h", bus.m_pixel, e.pix);
        end
        compared++;
        if (bus.m_y !== e.y || bus.m_x !== e.x) begin
          mismatched++;
          $display("[TB] FAIL sb_tag: got y=%0d x=%0d, expected y=%0d x=%0d",
                   bus.m_y, bus.m_x, e.y, e.x);
        end
        compared++;
        if (bus.m_last !== e.last) begin
          mismatched++;
          $display("[TB] FAIL sb_last: got %b, expected %b", bus.m_last, e.last);
        end
        if (e.last) lastHsCyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExp(input pix_t p, input int y, input int x);
    exp_t e;
    e.pix  = p;
    e.y    = 4'(y);
    e.x    = 4'(x);
    e.last = (y == IMG_H - 1) && (x == IMG_W - 1);
    sbQueue.push_back(e);
  endtask

  // Holds an element on the bus until it is accepted. Entered and left
  // one time unit after a rising edge; s_valid is left high.
  task automatic sendElem(input int f, input int d, input int y, input int x);
    bit acc;
    int waitCyc;
    bus.s_filter = 5'(f);
    bus.s_data   = 8'(d);
    bus.s_y      = 4'(y);
    bus.s_x      = 4'(x);
    bus.s_valid  = 1'b1;
    acc = 1'b0;
    waitCyc = 0;
    while (!acc && waitCyc < 300) begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk);
      #1;
      waitCyc++;
    end
    compared++;
    if (!acc) begin
      mismatched++;
      $display("[TB] FAIL send_timeout: got no accept for f=%0d, expected accept", f);
    end
  endtask

  task automatic sendPixel(input int y, input int x, input pix_t p);
    for (int f = 0; f < OUT_CH; f++) sendElem(f, int'(p[f]), y, x);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbQueue.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b1;
    bus.s_filter = '0;
    @(negedge clk);
    compared++;
    if (bus.s_ready !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_s_ready: got %b, expected 0", bus.s_ready);
    end
    compared++;
    if (bus.m_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_m_valid: got %b, expected 0", bus.m_valid);
    end
    compared++;
    if (bus.m_pixel !== '0 || bus.m_y !== '0 || bus.m_x !== '0 || bus.m_last !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got pixel=%h y=%0d x=%0d last=%b, expected all 0",
               bus.m_pixel, bus.m_y, bus.m_x, bus.m_last);
    end
    compared++;
    if (frameDone !== 1'b0 || errSeq !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got frame_done=%b err_seq=%b, expected 0 0", frameDone, errSeq);
    end
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.s_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL post_reset_s_ready: got %b, expected 1", bus.s_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_one_pixel();
    pix_t p;
    int unsigned start;
    for (int k = 0; k < OUT_CH; k++) p[k] = 8'(k - 16);
    pushExp(p, 3, 5);
    bus.m_ready = 1'b1;
    start = cyc;
    for (int f = 0; f < OUT_CH - 1; f++) sendElem(f, f - 16, 3, 5);
    compared++;
    if (cyc - start !== 31) begin
      mismatched++; $display("[TB] FAIL one_pixel_rate: got %0d cycles, expected 31", cyc - start);
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.m_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL one_pixel_early: got m_valid=%b, expected 0", bus.m_valid);
    end
    @(posedge clk);
    #1;
    sendElem(31, 15, 3, 5);
    bus.s_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.m_valid !== 1'b1) begin
      mismatched++; $display("[TB] FAIL one_pixel_latency: got m_valid=%b, expected 1", bus.m_valid);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    compared++;
    if (bus.m_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL one_pixel_pulse: got m_valid=%b, expected 0", bus.m_valid);
    end
    @(posedge clk);
    #1;
    waitDrain();
    compared++;
    if (sbQueue.size() != 0) begin
      mismatched++; $display("[TB] FAIL one_pixel_drain: got %0d pending, expected 0", sbQueue.size());
    end
  endtask

  task automatic test_backpressure();
    pix_t p[3];
    for (int n = 0; n < 3; n++) begin
      for (int f = 0; f < OUT_CH; f++) p[n][f] = 8'(n * 37 + f * 5 + 1);
      pushExp(p[n], n + 1, n + 2);
    end
    bus.m_ready = 1'b0;
    sendPixel(1, 2, p[0]);
    sendPixel(2, 3, p[1]);
    bus.s_filter = '0;
    bus.s_data   = p[2][0];
    bus.s_y      = 4'd3;
    bus.s_x      = 4'd4;
    bus.s_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      compared++;
      if (bus.s_ready !== 1'b0) begin
        mismatched++; $display("[TB] FAIL bp_hold: got s_ready=%b in cycle %0d, expected 0", bus.s_ready, c);
      end
      compared++;
      if (bus.m_valid !== 1'b1 || bus.m_y !== 4'd1) begin
        mismatched++;
        $display("[TB] FAIL bp_present: got m_valid=%b m_y=%0d, expected 1 1", bus.m_valid, bus.m_y);
      end
      @(posedge clk);
      #1;
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.s_ready !== 1'b0) begin
      mismatched++; $display("[TB] FAIL bp_drain_cycle: got s_ready=%b, expected 0", bus.s_ready);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    compared++;
    if (bus.s_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL bp_reopen: got s_ready=%b, expected 1", bus.s_ready);
    end
    compared++;
    if (bus.m_valid !== 1'b1 || bus.m_y !== 4'd2) begin
      mismatched++;
      $display("[TB] FAIL bp_no_bubble: got m_valid=%b m_y=%0d, expected 1 2", bus.m_valid, bus.m_y);
    end
    @(posedge clk);
    #1;
    for (int f = 1; f < OUT_CH; f++) sendElem(f, int'(p[2][f]), 3, 4);
    bus.s_valid = 1'b0;
    waitDrain();
    compared++;
    if (sbQueue.size() != 0) begin
      mismatched++; $display("[TB] FAIL bp_drain: got %0d pending, expected 0", sbQueue.size());
    end
  endtask

  task automatic test_seq_error();
    pix_t e;
    pix_t r;
    bus.m_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (errSeq !== 1'b0) begin
      mismatched++; $display("[TB] FAIL seq_clean: got err_seq=%b, expected 0", errSeq);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < OUT_CH; k++) e[k] = 8'(k + 40);
    pushExp(e, 2, 4);
    sendElem(0, 40, 2, 4);
    sendElem(1, 41, 2, 4);
    sendElem(3, 99, 2, 4);
    bus.s_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (errSeq !== 1'b1) begin
      mismatched++; $display("[TB] FAIL seq_err_flag: got err_seq=%b, expected 1", errSeq);
    end
    compared++;
    if (bus.m_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL seq_no_output: got m_valid=%b, expected 0", bus.m_valid);
    end
    @(posedge clk);
    #1;
    for (int f = 2; f < OUT_CH; f++) sendElem(f, f + 40, 2, 4);
    bus.s_valid = 1'b0;
    waitDrain();
    compared++;
    if (sbQueue.size() != 0) begin
      mismatched++; $display("[TB] FAIL seq_resume_drain: got %0d pending, expected 0", sbQueue.size());
    end
    for (int k = 0; k < OUT_CH; k++) r[k] = 8'(-(k + 1));
    pushExp(r, 9, 10);
    for (int f = 0; f < 10; f++) sendElem(f, 1, 7, 8);
    sendElem(0, int'(r[0]), 9, 10);
    for (int f = 1; f < 5; f++) sendElem(f, int'(r[f]), 9, 10);
    sendElem(5, 77, 1, 10);
    for (int f = 5; f < OUT_CH; f++) sendElem(f, int'(r[f]), 9, 10);
    bus.s_valid = 1'b0;
    waitDrain();
    compared++;
    if (sbQueue.size() != 0) begin
      mismatched++; $display("[TB] FAIL seq_restart_drain: got %0d pending, expected 0", sbQueue.size());
    end
    compared++;
    if (errSeq !== 1'b1) begin
      mismatched++; $display("[TB] FAIL seq_sticky: got err_seq=%b, expected 1", errSeq);
    end
  endtask

  task automatic test_back_to_back();
    pix_t p;
    int unsigned start;
    bus.m_ready = 1'b1;
    start = cyc;
    for (int n = 0; n < 4; n++) begin
      for (int f = 0; f < OUT_CH; f++) p[f] = 8'($urandom);
      pushExp(p, n, 13 - n);
      sendPixel(n, 13 - n, p);
    end
    compared++;
    if (cyc - start !== 4 * OUT_CH) begin
      mismatched++;
      $display("[TB] FAIL b2b_rate: got %0d cycles, expected %0d", cyc - start, 4 * OUT_CH);
    end
    bus.s_valid = 1'b0;
    waitDrain();
    compared++;
    if (sbQueue.size() != 0) begin
      mismatched++; $display("[TB] FAIL b2b_drain: got %0d pending, expected 0", sbQueue.size());
    end
  endtask

  task automatic test_frame_end();
    bit aDone = 1'b0;
    int pulses = 0;
    int unsigned pulseCyc = 0;
    bus.m_ready = 1'b1;
    fork
      begin
        pix_t p;
        for (int y = 0; y < IMG_H; y++) begin
          for (int x = 0; x < IMG_W; x++) begin
            for (int f = 0; f < OUT_CH; f++) p[f] = 8'(y * IMG_W + x + f * 3);
            pushExp(p, y, x);
            sendPixel(y, x, p);
          end
        end
        bus.s_valid = 1'b0;
        aDone = 1'b1;
      end
      begin
        int tail = 0;
        while (tail < 5) begin
          @(negedge clk);
          if (frameDone) begin
            pulses++;
            pulseCyc = cyc;
          end
          if (aDone) tail++;
        end
      end
    join
    compared++;
    if (pulses != 1) begin
      mismatched++; $display("[TB] FAIL frame_done_count: got %0d pulses, expected 1", pulses);
    end
    compared++;
    if (pulseCyc != lastHsCyc + 1) begin
      mismatched++;
      $display("[TB] FAIL frame_done_timing: got cycle %0d, expected %0d", pulseCyc, lastHsCyc + 1);
    end
    compared++;
    if (sbQueue.size() != 0) begin
      mismatched++; $display("[TB] FAIL frame_drain: got %0d pending, expected 0", sbQueue.size());
    end
  endtask

  task automatic test_reset_midfill();
    pix_t q;
    bus.m_ready = 1'b1;
    for (int f = 0; f < 10; f++) sendElem(f, f, 4, 4);
    sendElem(5, 0, 4, 4);
    bus.s_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (errSeq !== 1'b1) begin
      mismatched++; $display("[TB] FAIL midfill_err_set: got err_seq=%b, expected 1", errSeq);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.s_valid = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || errSeq !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midfill_reset: got s_ready=%b m_valid=%b err_seq=%b, expected 0 0 0",
               bus.s_ready, bus.m_valid, errSeq);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.s_valid = 1'b0;
    for (int k = 0; k < OUT_CH; k++) q[k] = 8'(k * 7);
    pushExp(q, 6, 6);
    sendPixel(6, 6, q);
    bus.s_valid = 1'b0;
    waitDrain();
    compared++;
    if (sbQueue.size() != 0) begin
      mismatched++; $display("[TB] FAIL midfill_drain: got %0d pending, expected 0", sbQueue.size());
    end
    compared++;
    if (errSeq !== 1'b0) begin
      mismatched++; $display("[TB] FAIL midfill_err_clear: got err_seq=%b, expected 0", errSeq);
    end
  endtask

  task automatic test_extremes_flush();
    pix_t a;
    pix_t b;
    for (int k = 0; k < OUT_CH; k++) begin
      a[k] = (k % 2 == 0) ? 8'h80 : 8'h7F;
      b[k] = (k % 2 == 0) ? 8'h7F : 8'h80;
    end
    bus.m_ready = 1'b1;
    pushExp(a, 0, 1);
    sendPixel(0, 1, a);
    bus.s_valid = 1'b0;
    waitDrain();
    compared++;
    if (sbQueue.size() != 0) begin
      mismatched++; $display("[TB] FAIL extremes_drain: got %0d pending, expected 0", sbQueue.size());
    end
    bus.m_ready = 1'b0;
    sendPixel(1, 1, a);
    sendPixel(1, 2, b);
    bus.s_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL flush_setup: got s_ready=%b m_valid=%b, expected 0 1", bus.s_ready, bus.m_valid);
    end
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL flush_clear: got m_valid=%b s_ready=%b, expected 0 1", bus.m_valid, bus.s_ready);
    end
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.m_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL flush_stays_empty: got m_valid=%b, expected 0", bus.m_valid);
    end
    @(posedge clk);
    #1;
    pushExp(b, 5, 5);
    sendPixel(5, 5, b);
    bus.s_valid = 1'b0;
    waitDrain();
    compared++;
    if (sbQueue.size() != 0) begin
      mismatched++; $display("[TB] FAIL post_flush_drain: got %0d pending, expected 0", sbQueue.size());
    end
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.s_filter = '0;
    bus.s_y      = '0;
    bus.s_x      = '0;
    bus.m_ready  = 1'b0;
    test_reset();
    test_one_pixel();
    test_backpressure();
    test_seq_error();
    test_back_to_back();
    test_frame_end();
    test_reset_midfill();
    test_extremes_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fmap_channel_packer.md
Name: fmap_channel_packer

Overview:
- Sits after the conv2 requantizer, at the far end of the conv2 output stream.
- Receives filter-serial int8 results: one element per cycle, tagged with filter index f and pixel (y, x), filters 0..OUT_CH-1 in order for each pixel.
- Packs each pixel's OUT_CH values into one channel-parallel vector and transmits it on a valid/ready stream.
- The output has the same channel-parallel shape conv2 consumes on its input, so conv3/pool stages can take it directly.
- Double-buffered (ping-pong), so filling one pixel overlaps draining the previous one.

Parameters:
- OUT_CH, 32, channels per packed pixel (filters of producing layer).
- IMG_H, 14, feature-map height.
- IMG_W, 14, feature-map width.
- DATA_W, 8, element width (signed int8).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear: drops partial fill and both banks.
- s_data  in  DATA_W  signed element.
- s_filter  in  $clog2(OUT_CH)  filter index of s_data.
- s_y  in  $clog2(IMG_H)  row tag.
- s_x  in  $clog2(IMG_W)  column tag.
- s_valid  in  1  element valid.
- s_ready  out  1  element accepted when s_valid&&s_ready.
- m_pixel  out  DATA_W x [0:OUT_CH-1]  packed signed vector, index = filter.
- m_y  out  $clog2(IMG_H)  row of m_pixel.
- m_x  out  $clog2(IMG_W)  column of m_pixel.
- m_last  out  1  m_y==IMG_H-1 && m_x==IMG_W-1.
- m_valid  out  1  vector valid.
- m_ready  in  1  downstream accepts.
- frame_done  out  1  one-cycle pulse after last pixel of frame transferred.
- err_seq  out  1  sticky sequence-error flag.

Behaviour:
- Reset (async): both banks EMPTY, wr_bank=rd_bank=0, fill_cnt=0, all vectors/tags 0, m_valid=0, m_pixel=0, m_y=m_x=0, m_last=0, frame_done=0, err_seq=0.
- s_ready: 0 while rst is high; otherwise 1 iff bank[wr_bank] != FULL and flush=0.
- Bank state per bank: EMPTY -> FILLING (first element accepted) -> FULL (OUT_CH-th element accepted) -> EMPTY (output handshake).
- Accept rule: the expected filter is fill_cnt.
  - s_filter==fill_cnt: write s_data to slot fill_cnt; fill_cnt++.
  - At fill_cnt==0: capture s_y/s_x as the bank tag.
- Mismatch in s_filter, or y/x differing from the captured tag while fill_cnt>0:
  - err_seq<=1 (sticky until rst).
  - If s_filter==0: restart the fill with this element (fill_cnt=1, new tag).
  - Otherwise: drop the element and leave fill_cnt unchanged.
  - s_ready is still 1 for the dropped element; it is never stalled.
- Completion: accepting filter OUT_CH-1 marks the bank FULL, toggles wr_bank and sets fill_cnt=0, all in the same edge.
- Output is driven directly from bank[rd_bank] registers.
  - m_valid = bank[rd_bank]==FULL.
  - m_pixel, m_y, m_x, m_last are stable while m_valid && !m_ready.
- Latency: the last element is accepted at edge t; m_valid=1 after edge t (visible the cycle after acceptance).
- On m_valid&&m_ready: bank[rd_bank] goes EMPTY and rd_bank toggles. A second FULL bank presents on the next cycle with no bubble.
- Simultaneous completion of one bank and drain of the other in the same cycle are both honoured.
- Throughput: with m_ready=1, sustains 1 element/cycle indefinitely.
- Both banks FULL: s_ready=0 until a drain. A drain in cycle c makes s_ready=1 in cycle c+1.
- frame_done: registered pulse, high the cycle after a handshake with m_last=1.
- flush: at the next edge, both banks EMPTY, fill_cnt=0, m_valid=0. Pointers and err_seq are kept. flush has priority over a same-cycle accept or drain.
- Mid-operation reset: all state discarded. The next accepted element must be filter 0 to avoid err_seq.

Test Plan:
- One pixel: s_filter 0..31, s_data=f-16, y=3, x=5, m_ready=1 -> m_valid the cycle after f=31 is accepted; m_pixel[k]=k-16, m_y=3, m_x=5, m_last=0; m_valid high exactly 1 cycle.
- Backpressure: m_ready=0, stream 3 pixels -> s_ready drops to 0 after 64 accepts and the third pixel's f=0 is held. m_ready=1 -> pixels emerge in order 1, 2, 3; all 96 elements intact; no loss or duplication.
- Sequence error: filters 0, 1, 3 -> err_seq=1, element 3 dropped. Then 2..31 -> one vector with slots 0..31 correct. A later f=0 mid-fill restarts the fill and the output uses the new tag.
- Frame end: 196 pixels raster-order (y,x 0..13) -> m_last=1 only on (13,13); frame_done pulses once, one cycle after that handshake.
- Reset mid-fill: 10 elements then rst -> m_valid=0, err_seq=0, s_ready=0 during rst. Next full pixel outputs correctly.
- Extremes: s_data alternating -128/127 -> m_pixel slots reproduce -128/127 bit-exact. flush with both banks FULL -> m_valid=0 next cycle and s_ready=1.
